// File: rtl/denoise_strip_sched_if.sv
// rtl/denoise_strip_sched_if.sv - pixel RAM read port and denoise input stream bundle
//
// Purpose: groups the frame-RAM read port and the serialized pixel stream that
//          feeds the denoise block.
// Signals:
//   mem_rd_en    RAM read strobe (scheduler -> RAM)
//   mem_addr     RAM read address (scheduler -> RAM)
//   mem_rd_data  RAM read data, valid the cycle after mem_rd_en (RAM -> scheduler)
//   pix_data     stream pixel component (scheduler -> denoise)
//   pix_valid    stream valid
//   pix_color    component index 0=R 1=G 2=B, 3 when idle
//   pix_last     last component of a strip
// Modports: master = scheduler side, slave = RAM/denoise side.
interface denoise_strip_sched_if #(
  parameter int COLOR_DEPTH = 8,
  parameter int ADDR_W      = 16
);
  logic                   mem_rd_en;
  logic [ADDR_W-1:0]      mem_addr;
  logic [COLOR_DEPTH-1:0] mem_rd_data;
  logic [COLOR_DEPTH-1:0] pix_data;
  logic                   pix_valid;
  logic [2:0]             pix_color;
  logic                   pix_last;

  modport master (
    output mem_rd_en, mem_addr, pix_data, pix_valid, pix_color, pix_last,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_en, mem_addr, pix_data, pix_valid, pix_color, pix_last,
    output mem_rd_data
  );
endinterface

// File: rtl/denoise_strip_sched.sv
// rtl/denoise_strip_sched.sv - strip/column/row/colour read sequencer for the 3x3 denoise block
//
// Purpose: on start, walks an RGB frame in pixel RAM as 6-row strips with stride 4,
//          column-major inside a strip, rows top-down, components R,G,B, and forwards
//          the RAM data as the denoise input stream. Idle gaps of GAP_CYC cycles are
//          inserted between strips so the denoise pipeline can drain.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a frame (accepted only in IDLE)
//   abort               synchronous abort, returns to IDLE next cycle
//   pause               hold read issue while high (RUN only)
//   cfg_width/height    frame size, sampled on accepted start
//   cfg_base            frame base address, sampled on accepted start
//   busy                high while a frame is in progress
//   done                1-cycle pulse after the final stream component
//   err                 1-cycle pulse when start is rejected for a bad config
//   bus                 RAM read port + denoise stream (master modport)
module denoise_strip_sched #(
  parameter int COLOR_DEPTH = 8,
  parameter int DIM_W       = 8,
  parameter int ADDR_W      = 16,
  parameter int GAP_CYC     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         pause,
  input  logic [DIM_W-1:0]             cfg_width,
  input  logic [DIM_W-1:0]             cfg_height,
  input  logic [ADDR_W-1:0]            cfg_base,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  denoise_strip_sched_if.master        bus
);

  // Wide enough to hold base + 3*W*H without overflow.
  localparam int CHK_W = ADDR_W + 2 * DIM_W + 3;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state_q;
  logic [1:0]         c_q;
  logic [2:0]         r_q;
  logic [DIM_W-1:0]   col_q;
  logic [DIM_W-1:0]   strip_q;
  logic [DIM_W-1:0]   w_last_q;
  logic [DIM_W-1:0]   strip_last_q;
  logic [ADDR_W-1:0]  w3_q;
  logic [ADDR_W-1:0]  w12_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  col_ptr_q;
  logic [ADDR_W-1:0]  strip_ptr_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               pix_valid_q;
  logic [2:0]         pix_color_q;
  logic               pix_last_q;

  logic [CHK_W-1:0]   frame_end;
  logic               cfg_ok;
  logic               rd_en;
  logic               issue_ok;
  logic               last_of_strip;
  logic [ADDR_W-1:0]  next_strip_ptr;

  assign frame_end = CHK_W'(cfg_base)
                   + CHK_W'(cfg_width) * CHK_W'(cfg_height) * CHK_W'(3);

  // (H-2) % 4 == 0 is the same as H[1:0] == 2'b10.
  assign cfg_ok = (cfg_width >= DIM_W'(3)) &&
                  (cfg_height >= DIM_W'(6)) &&
                  (cfg_height[1:0] == 2'b10) &&
                  (frame_end <= (CHK_W'(1) << ADDR_W));

  assign rd_en          = (state_q == RUN) && !pause;
  // A read issued in the abort cycle is dropped from the stream.
  assign issue_ok       = rd_en && !abort;
  assign last_of_strip  = (c_q == 2'd2) && (r_q == 3'd5) && (col_q == w_last_q);
  assign next_strip_ptr = strip_ptr_q + w12_q;

  assign bus.mem_rd_en  = rd_en;
  assign bus.mem_addr   = addr_q;
  assign bus.pix_data   = bus.mem_rd_data;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_color  = pix_color_q;
  assign bus.pix_last   = pix_last_q;
  assign busy           = (state_q != IDLE);

  // addr_q always holds the address of the component at (strip, r, col, c).
  // col_ptr_q is the address of (top row, col, R) and strip_ptr_q the address of
  // (top row, column 0, R), so every step is an add instead of a multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      c_q          <= '0;
      r_q          <= '0;
      col_q        <= '0;
      strip_q      <= '0;
      w_last_q     <= '0;
      strip_last_q <= '0;
      w3_q         <= '0;
      w12_q        <= '0;
      addr_q       <= '0;
      col_ptr_q    <= '0;
      strip_ptr_q  <= '0;
      gap_cnt_q    <= '0;
      pix_valid_q  <= 1'b0;
      pix_color_q  <= 3'd3;
      pix_last_q   <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done        <= 1'b0;
      err         <= 1'b0;
      pix_valid_q <= issue_ok;
      pix_color_q <= issue_ok ? {1'b0, c_q} : 3'd3;
      pix_last_q  <= issue_ok && last_of_strip;

      if (abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                state_q      <= RUN;
                c_q          <= '0;
                r_q          <= '0;
                col_q        <= '0;
                strip_q      <= '0;
                w_last_q     <= cfg_width - DIM_W'(1);
                // (H-2)/4 strips, index of the last one is (H-6)/4.
                strip_last_q <= (cfg_height - DIM_W'(6)) >> 2;
                w3_q         <= ADDR_W'(cfg_width) * ADDR_W'(3);
                w12_q        <= ADDR_W'(cfg_width) * ADDR_W'(12);
                addr_q       <= cfg_base;
                col_ptr_q    <= cfg_base;
                strip_ptr_q  <= cfg_base;
              end else begin
                err <= 1'b1;
              end
            end
          end

          RUN: begin
            if (!pause) begin
              if (c_q != 2'd2) begin
                c_q    <= c_q + 2'd1;
                addr_q <= addr_q + ADDR_W'(1);
              end else if (r_q != 3'd5) begin
                // From B of this row to R of the next row, same column.
                c_q    <= '0;
                r_q    <= r_q + 3'd1;
                addr_q <= addr_q + w3_q - ADDR_W'(2);
              end else if (col_q != w_last_q) begin
                c_q       <= '0;
                r_q       <= '0;
                col_q     <= col_q + DIM_W'(1);
                addr_q    <= col_ptr_q + ADDR_W'(3);
                col_ptr_q <= col_ptr_q + ADDR_W'(3);
              end else begin
                c_q   <= '0;
                r_q   <= '0;
                col_q <= '0;
                if (strip_q == strip_last_q) begin
                  state_q <= DRAIN;
                end else begin
                  // Next strip starts 4 rows down: +12*W components.
                  strip_q     <= strip_q + DIM_W'(1);
                  addr_q      <= next_strip_ptr;
                  col_ptr_q   <= next_strip_ptr;
                  strip_ptr_q <= next_strip_ptr;
                  gap_cnt_q   <= '0;
                  state_q     <= (GAP_CYC == 0) ? RUN : GAP;
                end
              end
            end
          end

          GAP: begin
            // pause is deliberately not looked at here.
            if (gap_cnt_q == GAP_LAST) begin
              state_q <= RUN;
            end else begin
              gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end
          end

          DRAIN: begin
            state_q <= IDLE;
            done    <= 1'b1;
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_denoise_strip_sched.sv
// tb/tb_denoise_strip_sched.sv - self-checking bench for denoise_strip_sched
module tb_denoise_strip_sched;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        pause;
  logic [7:0]  cfg_width;
  logic [7:0]  cfg_height;
  logic [15:0] cfg_base;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  denoise_strip_sched_if #(.COLOR_DEPTH(8), .ADDR_W(16)) bus ();

  denoise_strip_sched #(
    .COLOR_DEPTH(8),
    .DIM_W(8),
    .ADDR_W(16),
    .GAP_CYC(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .pause(pause),
    .cfg_width(cfg_width),
    .cfg_height(cfg_height),
    .cfg_base(cfg_base),
    .busy(busy),
    .done(done),
    .err(err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Pixel RAM model, one cycle read latency.
  always @(posedge clk or posedge rst) begin
    if (rst) bus.mem_rd_data <= '0;
    else if (bus.mem_rd_en) bus.mem_rd_data <= mem_fn(bus.mem_addr);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int w;
    int h;
    int base;
    bit exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic run_frame(input string tag, input int w, input int h, input int base,
                           input int pause_at, input int pause_len);
    int exp_addr[$];
    int nstr, total, rd_cnt, v_cnt, last_cnt, addr_err, pix_err, paused_rd;
    int s0_last_cyc, s1_first_cyc, last_rd_cyc, done_cyc, busy_at_done;
    bit pz;
    nstr = (h - 2) / 4;
    for (int s = 0; s < nstr; s++)
      for (int col = 0; col < w; col++)
        for (int r = 0; r < 6; r++)
          for (int c = 0; c < 3; c++)
            exp_addr.push_back(base + 3 * ((4 * s + r) * w + col) + c);
    total = exp_addr.size();
    rd_cnt = 0; v_cnt = 0; last_cnt = 0; addr_err = 0; pix_err = 0; paused_rd = 0;
    s0_last_cyc = -1; s1_first_cyc = -1; last_rd_cyc = -100; done_cyc = -1; busy_at_done = -1;
    @(negedge clk);
    cfg_width = 8'(w); cfg_height = 8'(h); cfg_base = 16'(base); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      pz = (pause_len > 0) && (k >= pause_at) && (k < pause_at + pause_len);
      pause = pz;
      #1;
      if (bus.mem_rd_en) begin
        if (pz) paused_rd++;
        if (rd_cnt >= total) addr_err++;
        else if (int'(bus.mem_addr) != exp_addr[rd_cnt]) addr_err++;
        if (rd_cnt == 18 * w - 1) s0_last_cyc = k;
        if (rd_cnt == 18 * w) s1_first_cyc = k;
        last_rd_cyc = k;
        rd_cnt++;
      end
      if (bus.pix_valid) begin
        if (v_cnt >= total) pix_err++;
        else begin
          if (bus.pix_color != 3'(v_cnt % 3)) pix_err++;
          if (bus.pix_last != ((v_cnt % (18 * w)) == 18 * w - 1)) pix_err++;
          if (bus.pix_data != mem_fn(16'(exp_addr[v_cnt]))) pix_err++;
        end
        if (bus.pix_last) last_cnt++;
        v_cnt++;
      end else if (bus.pix_color != 3'd3 || bus.pix_last) begin
        pix_err++;
      end
      if (done) begin
        done_cyc = k;
        busy_at_done = int'(busy);
        break;
      end
      @(negedge clk);
    end
    pause = 1'b0;
    chk({tag, " rd_count"}, rd_cnt, total);
    chk({tag, " addr_errors"}, addr_err, 0);
    chk({tag, " valid_count"}, v_cnt, total);
    chk({tag, " last_count"}, last_cnt, nstr);
    chk({tag, " stream_errors"}, pix_err, 0);
    chk({tag, " done_latency"}, done_cyc - last_rd_cyc, 2);
    chk({tag, " busy_at_done"}, busy_at_done, 0);
    if (pause_len > 0) chk({tag, " reads_while_paused"}, paused_rd, 0);
    if (nstr > 1) chk({tag, " strip_gap"}, s1_first_cyc - s0_last_cyc, GAP + 1);
  endtask

  initial begin
    int n;
    vecs[0] = '{w: 3,   h: 6,   base: 0,     exp_err: 1'b0};
    vecs[1] = '{w: 2,   h: 6,   base: 0,     exp_err: 1'b1};
    vecs[2] = '{w: 3,   h: 8,   base: 0,     exp_err: 1'b1};
    vecs[3] = '{w: 3,   h: 5,   base: 0,     exp_err: 1'b1};
    vecs[4] = '{w: 3,   h: 2,   base: 0,     exp_err: 1'b1};
    vecs[5] = '{w: 3,   h: 6,   base: 65530, exp_err: 1'b1};
    vecs[6] = '{w: 3,   h: 6,   base: 65482, exp_err: 1'b0};
    vecs[7] = '{w: 3,   h: 6,   base: 65483, exp_err: 1'b1};
    vecs[8] = '{w: 255, h: 254, base: 0,     exp_err: 1'b1};
    vecs[9] = '{w: 3,   h: 10,  base: 0,     exp_err: 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_base = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst mem_rd_en", bus.mem_rd_en, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst pix_valid", bus.pix_valid, 0);
    chk("rst pix_color", bus.pix_color, 3);
    chk("rst pix_last", bus.pix_last, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    rst = 1'b0;

    // Config acceptance table.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cfg_width = 8'(vecs[i].w); cfg_height = 8'(vecs[i].h); cfg_base = 16'(vecs[i].base);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk($sformatf("cfg%0d err", i), err, vecs[i].exp_err);
      chk($sformatf("cfg%0d busy", i), busy, !vecs[i].exp_err);
      chk($sformatf("cfg%0d rd_en", i), bus.mem_rd_en, !vecs[i].exp_err);
      if (busy) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk($sformatf("cfg%0d abort_busy", i), busy, 0);
      end
      @(negedge clk);
      #1;
      chk($sformatf("cfg%0d err_pulse_end", i), err, 0);
    end

    // start and abort together in IDLE: abort wins.
    @(negedge clk);
    cfg_width = 8'd3; cfg_height = 8'd6; cfg_base = 16'd0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    chk("start_abort busy", busy, 0);
    chk("start_abort rd_en", bus.mem_rd_en, 0);
    chk("start_abort err", err, 0);

    run_frame("w3h6", 3, 6, 0, 0, 0);
    run_frame("w3h10", 3, 10, 100, 0, 0);
    run_frame("w4h6_pause", 4, 6, 5, 4, 3);
    run_frame("w3h10_pause_gap", 3, 10, 0, 54, 3);

    // Abort during strip 0, then restart from base.
    @(negedge clk);
    cfg_width = 8'd5; cfg_height = 8'd6; cfg_base = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort rd_en", bus.mem_rd_en, 0);
    chk("abort pix_valid", bus.pix_valid, 0);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (done || bus.pix_valid || bus.mem_rd_en) n++;
    end
    chk("abort quiet", n, 0);
    run_frame("restart", 5, 6, 7, 0, 0);

    // Asynchronous reset in the middle of the inter-strip gap.
    @(negedge clk);
    cfg_width = 8'd3; cfg_height = 8'd10; cfg_base = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (bus.mem_rd_en) n++;
      if (n == 54) break;
      @(negedge clk);
    end
    chk("gap_reach", n, 54);
    repeat (2) @(negedge clk);
    #1;
    chk("pre_rst in_gap", busy && !bus.mem_rd_en, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst busy", busy, 0);
    chk("async_rst rd_en", bus.mem_rd_en, 0);
    chk("async_rst pix_valid", bus.pix_valid, 0);
    chk("async_rst pix_color", bus.pix_color, 3);
    chk("async_rst pix_last", bus.pix_last, 0);
    chk("async_rst mem_addr", bus.mem_addr, 0);
    chk("async_rst done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame("post_rst", 3, 10, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
